// File: rtl/pump_pwm_gen.sv
// Two-channel pump PWM with a shared 255-tick frame, frame-aligned duty
// updates, rising-edge slew limiting and an emergency-stop override.
module pump_pwm_gen #(
    parameter int CLK_DIV   = 196,
    parameter int RAMP_STEP = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pwm_duty_a,
    input  logic [7:0] pwm_duty_b,
    input  logic       estop,
    output logic       pwm_out_a,
    output logic       pwm_out_b,
    output logic [7:0] duty_eff_a,
    output logic [7:0] duty_eff_b,
    output logic       period_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [8:0] STEP = 9'(RAMP_STEP);

    logic [PW-1:0] prescaler;
    logic [7:0]    cnt;
    logic          tick;
    logic          boundary;
    logic [7:0]    next_a;
    logic [7:0]    next_b;

    // Increase is clamped to the target; the 9-bit sum keeps it from wrapping.
    function automatic logic [7:0] ramp(input logic [7:0] e, input logic [7:0] t);
        logic [8:0] sum;
        sum = {1'b0, e} + STEP;
        if (t > e) begin
            ramp = (sum > {1'b0, t}) ? t : sum[7:0];
        end else begin
            ramp = t;
        end
    endfunction

    assign tick     = (prescaler == PRE_MAX);
    assign boundary = tick && (cnt == 8'd254);

    always_comb begin
        next_a = duty_eff_a;
        next_b = duty_eff_b;
        if (estop) begin
            next_a = 8'd0;
            next_b = 8'd0;
        end else if (boundary) begin
            next_a = ramp(duty_eff_a, pwm_duty_a);
            next_b = ramp(duty_eff_b, pwm_duty_b);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            cnt       <= 8'd0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                cnt <= (cnt == 8'd254) ? 8'd0 : cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_eff_a   <= 8'd0;
            duty_eff_b   <= 8'd0;
            pwm_out_a    <= 1'b0;
            pwm_out_b    <= 1'b0;
            period_start <= 1'b0;
        end else begin
            duty_eff_a   <= next_a;
            duty_eff_b   <= next_b;
            pwm_out_a    <= (cnt < duty_eff_a) && !estop;
            pwm_out_b    <= (cnt < duty_eff_b) && !estop;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pump_pwm_gen.sv
// Bench for pump_pwm_gen: time-based reference model compared every clk,
// plus directed ramp/estop/boundary scenarios and randomized traffic.
module tb_pump_pwm_gen;

    localparam int CD = 2;
    localparam int RS = 16;
    localparam int FRAME = 255 * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] duty_a = 8'd0;
    logic [7:0] duty_b = 8'd0;
    logic       estop = 1'b0;
    logic       pwm_out_a;
    logic       pwm_out_b;
    logic [7:0] duty_eff_a;
    logic [7:0] duty_eff_b;
    logic       period_start;

    int errors = 0;
    int checks = 0;

    pump_pwm_gen #(.CLK_DIV(CD), .RAMP_STEP(RS)) dut (
        .clk(clk),
        .reset(rst),
        .pwm_duty_a(duty_a),
        .pwm_duty_b(duty_b),
        .estop(estop),
        .pwm_out_a(pwm_out_a),
        .pwm_out_b(pwm_out_b),
        .duty_eff_a(duty_eff_a),
        .duty_eff_b(duty_eff_b),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int step(input int e, input int t, input int rs);
        if (t > e) return (e + rs > t) ? t : e + rs;
        return t;
    endfunction

    // Reference model: position in the frame derives from clocks since reset.
    int n = 0;
    int me_a = 0, me_b = 0;
    int x_a = 0, x_b = 0, x_ps = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0; me_a = 0; me_b = 0;
                x_a = 0; x_b = 0; x_ps = 0;
            end else begin
                int c;
                bit bnd;
                c = (n / CD) % 255;
                bnd = (n % FRAME) == FRAME - 1;
                x_a = (c < me_a) && !estop;
                x_b = (c < me_b) && !estop;
                x_ps = bnd;
                if (estop) begin
                    me_a = 0; me_b = 0;
                end else if (bnd) begin
                    me_a = step(me_a, duty_a, RS);
                    me_b = step(me_b, duty_b, RS);
                end
                n++;
            end
            #1;
            check("pwm_out_a", pwm_out_a, x_a);
            check("pwm_out_b", pwm_out_b, x_b);
            check("duty_eff_a", duty_eff_a, me_a);
            check("duty_eff_b", duty_eff_b, me_b);
            check("period_start", period_start, x_ps);
        end
    end

    task automatic wait_boundary();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < FRAME + 90);
        if (!period_start) check("boundary_timeout", 0, 1);
    endtask

    task automatic count_high(output int ha);
        ha = 0;
        repeat (FRAME) begin
            @(negedge clk);
            ha += pwm_out_a;
        end
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 3))
            0: return 8'd0;
            1: return 8'd255;
            2: return 8'($urandom_range(240, 255));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int k;
        int ha;
        check("model_sat", step(240, 250, 16), 250);
        check("model_ovf", step(100, 255, 200), 255);
        check("model_drop", step(230, 77, 16), 77);

        repeat (3) @(negedge clk);
        check("rst_eff_a", duty_eff_a, 0);
        check("rst_out_a", pwm_out_a, 0);
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 600);
        check("first_ps_latency", k, 510);

        duty_a = 8'd230;
        for (int b = 1; b <= 16; b++) begin
            wait_boundary();
            check("ramp_230", duty_eff_a, (16 * b > 230) ? 230 : 16 * b);
        end
        @(negedge clk);
        count_high(ha);
        check("high_230", ha, 460);

        duty_a = 8'd250;
        wait_boundary();
        check("ramp_246", duty_eff_a, 246);
        duty_a = 8'd255;
        wait_boundary();
        check("ramp_sat_255", duty_eff_a, 255);
        @(negedge clk);
        count_high(ha);
        check("high_255", ha, 510);

        repeat (100) @(negedge clk);
        duty_a = 8'd77;
        duty_b = 8'd50;
        repeat (50) @(negedge clk);
        duty_b = 8'd0;
        repeat (50) @(negedge clk);
        duty_b = 8'd50;
        check("b_ignores_midframe", duty_eff_b, 0);
        wait_boundary();
        check("drop_77", duty_eff_a, 77);
        check("b_at_boundary", duty_eff_b, 16);
        @(negedge clk);
        count_high(ha);
        check("high_77", ha, 154);

        wait_boundary();
        repeat (20) @(negedge clk);
        check("pre_estop_out", pwm_out_a, 1);
        estop = 1'b1;
        @(negedge clk);
        check("estop_out_a", pwm_out_a, 0);
        check("estop_eff_a", duty_eff_a, 0);
        repeat (2) @(negedge clk);
        estop = 1'b0;
        wait_boundary();
        check("post_estop_16", duty_eff_a, 16);
        repeat (FRAME - 1) @(negedge clk);
        estop = 1'b1;
        @(negedge clk);
        estop = 1'b0;
        check("estop_at_bnd_eff", duty_eff_a, 0);
        check("estop_at_bnd_ps", period_start, 1);
        wait_boundary();
        check("after_bnd_estop", duty_eff_a, 16);

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) duty_a = pick();
            if ($urandom_range(0, 299) == 0) duty_b = pick();
            if (estop) estop = ($urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 1999) == 0) estop = 1'b1;
            if (i == 12345) begin
                rst = 1'b1;
                #1;
                check("async_rst_out", pwm_out_a | pwm_out_b, 0);
                check("async_rst_eff", duty_eff_a | duty_eff_b, 0);
                check("async_rst_ps", period_start, 0);
            end
            if (i == 12349) rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
